// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-state encoding and default reset/step constants
package fetch_unit_pkg;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: power-of-two circular FIFO with synchronous flush and occupancy count
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    // occupancy follows push/pop; both together leave it unchanged
    always_comb begin
        count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_d;
        end
    end

    // storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (push_i)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited instruction fetch, redirect flush and drain
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = DEFAULT_PC_STEP,
    parameter int                FQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_e                state_q, state_d;
    logic [ADDR_W-1:0]           pc_q, pc_d;
    logic [CW-1:0]               inflight_q, inflight_d;
    logic [CW-1:0]               drop_q, drop_d;
    logic [CW-1:0]               q_count, pend_count;
    logic [ADDR_W-1:0]           pend_pc;
    logic [ADDR_W+INSTR_W-1:0]   q_rdata;
    logic                        accept, rsp_run, q_pop;

    // a request only goes out when its response is guaranteed a queue slot
    assign imem_req_valid = !reset && !redirect_valid && state_q == RUN &&
                            ({1'b0, q_count} + {1'b0, inflight_q}) < (CW+1)'(FQ_DEPTH);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_run        = imem_rsp_valid && state_q == RUN && !redirect_valid && pend_count != '0;
    assign q_pop          = out_valid && out_ready && !redirect_valid;
    assign out_valid      = q_count != '0;
    assign out_pc         = out_valid ? q_rdata[ADDR_W+INSTR_W-1:INSTR_W] : '0;
    assign out_instr      = out_valid ? q_rdata[INSTR_W-1:0] : '0;

    // next PC, in-flight tracking and the RUN/DRAIN decision
    always_comb begin
        pc_d       = redirect_valid ? redirect_addr : accept ? pc_q + ADDR_W'(PC_STEP) : pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
        state_d    = state_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // every outstanding response belongs to a discarded path
            drop_d  = inflight_q - CW'(imem_rsp_valid);
            state_d = drop_d != '0 ? DRAIN : RUN;
        end else if (state_q == DRAIN && imem_rsp_valid) begin
            drop_d  = drop_q - 1'b1;
            state_d = drop_q == CW'(1) ? RUN : DRAIN;
        end
    end

    // state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.W(ADDR_W), .DEPTH(FQ_DEPTH)) u_pend (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (accept),
        .wdata_i (pc_q),
        .pop_i   (rsp_run),
        .rdata_o (pend_pc),
        .count_o (pend_count)
    );

    fetch_fifo #(.W(ADDR_W + INSTR_W), .DEPTH(FQ_DEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_run),
        .wdata_i ({pend_pc, imem_rsp_data}),
        .pop_i   (q_pop),
        .rdata_o (q_rdata),
        .count_o (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written redirect/reset sequences
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int errs = 0;
    int checks = 0;

    // memory model: manual drive for the table, fixed-latency pipe otherwise
    logic        man;
    logic        m_v;
    logic [31:0] m_d;
    int          lat;
    logic [7:0]  pv;
    logic [31:0] pa [8];

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pv <= '0;
        end else begin
            pv <= {pv[6:0], imem_req_valid && imem_req_ready};
            for (int i = 7; i > 0; i--) pa[i] <= pa[i-1];
            pa[0] <= imem_req_addr;
        end
    end

    assign imem_rsp_valid = man ? m_v : pv[lat-1];
    assign imem_rsp_data  = man ? m_d : (32'hC0DE_0000 | pa[lat-1]);

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ordy;
        logic        ev;
        logic [31:0] ea;
        logic        eo;
        logic [31:0] ep;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        man            = 1'b1;
        m_v            = 1'b0;
        m_d            = '0;
        lat            = 1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        nxt();
        nxt();
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        tv[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tv[1]  = '{1'b1, 1'b1, 32'hC0DE_0000, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tv[2]  = '{1'b1, 1'b1, 32'hC0DE_0004, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tv[3]  = '{1'b1, 1'b1, 32'hC0DE_0008, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tv[4]  = '{1'b0, 1'b1, 32'hC0DE_000C, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tv[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        tv[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 1'b0, 32'h00};
        tv[7]  = '{1'b1, 1'b1, 32'hC0DE_0010, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
        tv[8]  = '{1'b0, 1'b1, 32'hC0DE_0014, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tv[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tv[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tv[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
        tv[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h18, 1'b0, 32'h00};

        // sequential fetch, memory stall and decode backpressure from the table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            imem_req_ready = tv[i].rdy;
            m_v            = tv[i].rv;
            m_d            = tv[i].rd;
            out_ready      = tv[i].ordy;
            #1;
            chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tv[i].ev);
            if (tv[i].ev) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tv[i].ea);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tv[i].eo);
            if (tv[i].eo) begin
                chk($sformatf("tbl%0d_out_pc", i), out_pc, tv[i].ep);
                chk($sformatf("tbl%0d_out_instr", i), out_instr, 32'hC0DE_0000 | tv[i].ep);
            end
            nxt();
        end

        // decode stalled: credit limit caps requests at the queue depth
        do_reset();
        man = 1'b0;
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req_valid) n++;
            if (i >= 2) chk($sformatf("hold%0d_out", i), {out_valid, out_pc}, {1'b1, 32'h0});
            nxt();
        end
        #1;
        chk("credit_req_count", n, 4);
        chk("credit_req_idle", imem_req_valid, 0);
        out_ready = 1'b1;
        #1;
        chk("credit_release_pc0", {out_valid, out_pc}, {1'b1, 32'h0});
        nxt();
        #1;
        chk("credit_release_pc4", {out_valid, out_pc}, {1'b1, 32'h4});

        // redirect with three requests in flight drains three responses
        do_reset();
        man = 1'b0;
        lat = 4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("drn_issue%0d", i), {imem_req_valid, imem_req_addr}, {1'b1, 32'(i * 4)});
            nxt();
        end
        #1;
        chk("drn_pre_redirect", {imem_req_valid, imem_req_addr}, {1'b1, 32'hC});
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        #1;
        chk("drn_redirect_noreq", imem_req_valid, 0);
        nxt();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("drn_noreq%0d", i), imem_req_valid, 0);
            chk($sformatf("drn_noout%0d", i), out_valid, 0);
            nxt();
        end
        #1;
        chk("drn_target_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
        nxt();
        k = 0;
        while (!out_valid && k < 20) begin
            nxt();
            k++;
        end
        chk("drn_target_latency", k, 4);
        chk("drn_target_out", {out_valid, out_pc}, {1'b1, 32'h100});
        chk("drn_target_instr", out_instr, 32'hC0DE_0100);

        // redirect coinciding with a response and a decode pop
        do_reset();
        man = 1'b0;
        lat = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("col_issue%0d", i), {imem_req_valid, imem_req_addr}, {1'b1, 32'(i * 4)});
            nxt();
        end
        #1;
        chk("col_pre_out", {out_valid, out_pc}, {1'b1, 32'h0});
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        #1;
        chk("col_redirect_noreq", imem_req_valid, 0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk("col_flushed", out_valid, 0);
        chk("col_drain_one", imem_req_valid, 0);
        nxt();
        #1;
        chk("col_target_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h200});
        chk("col_still_empty", out_valid, 0);

        // PC wraps modulo 2^32
        do_reset();
        man = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFF8;
        #1;
        chk("wrap_redirect_noreq", imem_req_valid, 0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_req_f8", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFF8});
        nxt();
        #1;
        chk("wrap_req_fc", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFFC});
        nxt();
        #1;
        chk("wrap_req_0", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        chk("wrap_out_f8", {out_valid, out_pc}, {1'b1, 32'hFFFF_FFF8});
        nxt();
        #1;
        chk("wrap_out_fc", {out_valid, out_pc}, {1'b1, 32'hFFFF_FFFC});
        nxt();
        #1;
        chk("wrap_out_0", {out_valid, out_pc, out_instr}, {1'b1, 32'h0, 32'hC0DE_0000});

        // asynchronous reset with a loaded queue and requests in flight
        do_reset();
        man = 1'b0;
        lat = 3;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) nxt();
        #1;
        chk("ar_credit_full", imem_req_valid, 0);
        nxt();
        #1;
        chk("ar_pre_out", {out_valid, out_pc}, {1'b1, 32'h0});
        reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_req_valid", imem_req_valid, 0);
        chk("ar_out_data", {out_pc, out_instr}, 64'h0);
        nxt();
        reset = 1'b0;
        lat = 1;
        #1;
        chk("ar_restart_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        nxt();
        #1;
        chk("ar_restart_empty", out_valid, 0);
        nxt();
        #1;
        chk("ar_restart_out", {out_valid, out_pc}, {1'b1, 32'h0});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
